kvs_req_arbiter: RTL

KVS_REQ_ARBITER -- requirements
Module: kvs_req_arbiter

---
 rtl/kvs_arb_pkg.sv | 17 +
 rtl/kvs_arb_tag_fifo.sv | 61 ++++++
 rtl/kvs_req_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/kvs_arb_pkg.sv
// Shared types and constants for the KVS request arbiter: FSM state encoding,
// tag width helper and the packet counter width.
package kvs_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int CNT_W = 32;

  // A tag carries a requester index, so it needs enough bits to name NUM_REQ ports.
  function automatic int tag_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/kvs_arb_tag_fifo.sv
// Synchronous tag FIFO holding the requester index of every packet still
// waiting for its response. Push is ignored when full, pop when empty.
module kvs_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop cancel out in the occupancy count.
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/kvs_req_arbiter.sv
// Round-robin packet arbiter from NUM_REQ request streams onto one engine,
// with in-order response routing by tag. Define KVS_ARB_STATS_EN for per-requester packet counters.
module kvs_req_arbiter
  import kvs_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int C_DATA_WIDTH = 512,
  parameter int TAG_DEPTH    = 16
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_tvalid,
  output logic [NUM_REQ-1:0]              req_tready,
  input  logic [NUM_REQ-1:0]              req_tlast,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0] req_tdata,
  output logic                            eng_tvalid,
  input  logic                            eng_tready,
  output logic                            eng_tlast,
  output logic [C_DATA_WIDTH-1:0]         eng_tdata,
  input  logic                            rsp_in_tvalid,
  output logic                            rsp_in_tready,
  input  logic [C_DATA_WIDTH-1:0]         rsp_in_tdata,
  output logic [NUM_REQ-1:0]              rsp_tvalid,
  input  logic [NUM_REQ-1:0]              rsp_tready,
  output logic [C_DATA_WIDTH-1:0]         rsp_tdata,
  output logic                            busy,
  output logic [$clog2(TAG_DEPTH):0]      outstanding,
  output logic                            err_orphan,
  output logic [NUM_REQ*CNT_W-1:0]        pkt_cnt,
  output logic                            dbg_state
);

  localparam int IDX_W = tag_w(NUM_REQ);

  // All streams use AXI-Stream rules: a beat moves on a rising edge where
  // valid and ready are both high; valid never waits on ready.

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pushed_q, pushed_d;

  logic [C_DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_id;
  logic [IDX_W-1:0]        scan_idx;
  logic                    beat;
  logic                    tag_push, tag_pop;
  logic [IDX_W-1:0]        tag_head;
  logic                    fifo_full, fifo_empty;
  logic                    err_orphan_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_data_arr[i] = req_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  // Scan from the highest offset down so the last hit is the nearest one at or after rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_tvalid[scan_idx]) begin
        pick_valid = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  assign beat = (state_q == XFER) & req_tvalid[gnt_id_q] & eng_tready;

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    pushed_d   = pushed_q;
    tag_push   = 1'b0;
    eng_tvalid = 1'b0;
    eng_tlast  = 1'b0;
    eng_tdata  = '0;
    req_tready = '0;
    case (state_q)
      IDLE: begin
        // Full is the registered occupancy, so a pop this cycle only helps next cycle.
        if (pick_valid && !fifo_full) begin
          gnt_id_d = pick_id;
          pushed_d = 1'b0;
          state_d  = XFER;
        end
      end
      XFER: begin
        eng_tvalid           = req_tvalid[gnt_id_q];
        eng_tlast            = req_tlast[gnt_id_q];
        eng_tdata            = req_data_arr[gnt_id_q];
        req_tready[gnt_id_q] = eng_tready;
        if (beat) begin
          tag_push = ~pushed_q;
          pushed_d = 1'b1;
          if (req_tlast[gnt_id_q]) begin
            rr_ptr_d = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDX_W'(1);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      pushed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      pushed_q <= pushed_d;
    end
  end

  kvs_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (ap_clk),
    .rst         (areset),
    .push_i      (tag_push),
    .push_data_i (gnt_id_q),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding)
  );

  // Responses come back in packet order, so the FIFO head names the owner.
  always_comb begin
    rsp_tvalid    = '0;
    rsp_in_tready = rsp_tready[tag_head] & ~fifo_empty;
    if (rsp_in_tvalid && !fifo_empty) rsp_tvalid[tag_head] = 1'b1;
  end

  assign rsp_tdata = rsp_in_tdata;
  assign tag_pop   = rsp_in_tvalid & rsp_in_tready;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)                           err_orphan_q <= 1'b0;
    else if (rsp_in_tvalid && fifo_empty) err_orphan_q <= 1'b1;
  end

  assign err_orphan = err_orphan_q;
  assign busy       = (state_q == XFER) | ~fifo_empty;
  assign dbg_state  = state_q;

`ifdef KVS_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic             pkt_done;

  assign pkt_done = beat & req_tlast[gnt_id_q];

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (pkt_done && (cnt_q[gnt_id_q] != '1)) begin
      cnt_q[gnt_id_q] <= cnt_q[gnt_id_q] + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule
